// File: rtl/video_sprite_loader_if.sv
// ---------------------------------------------------------------------------
// video_sprite_loader_if : command, byte-stream and sprite RAM write bundle
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef RGB_SIZE
`define RGB_SIZE 12
`endif

interface video_sprite_loader_if #(
  parameter int SPRITE_IDXW   = 2,
  parameter int SPRITE_RAM_AW = 12,
  parameter int RGB_SIZE      = `RGB_SIZE
);
  logic                     start;
  logic [SPRITE_IDXW-1:0]   start_idx;
  logic                     abort;
  logic                     s_vld;
  logic [7:0]               s_data;
  logic                     s_rdy;
  logic                     busy;
  logic                     done;
  logic                     error;
  logic                     sprite_ram_we;
  logic [SPRITE_RAM_AW-1:0] sprite_ram_addr_w;
  logic [RGB_SIZE-1:0]      sprite_ram_din;

  // Loader side
  modport slave (
    input  start, start_idx, abort, s_vld, s_data,
    output s_rdy, busy, done, error,
    output sprite_ram_we, sprite_ram_addr_w, sprite_ram_din
  );

  // Controller / byte source side
  modport master (
    output start, start_idx, abort, s_vld, s_data,
    input  s_rdy, busy, done, error,
    input  sprite_ram_we, sprite_ram_addr_w, sprite_ram_din
  );
endinterface

`default_nettype wire

// File: rtl/video_sprite_loader.sv
// ---------------------------------------------------------------------------
// video_sprite_loader : fills one sprite RAM image slot from a 2-byte/pixel stream
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`ifndef RGB_SIZE
`define RGB_SIZE 12
`endif

module video_sprite_loader #(
  parameter int SPRITE_HSIZE  = 32,
  parameter int SPRITE_VSIZE  = 32,
  parameter int SPRITE_AW     = 10,
  parameter int SPRITE_IDXW   = 2,
  parameter int SPRITE_RAM_AW = SPRITE_AW + SPRITE_IDXW,
  parameter int SPRITE_NUM    = 4
) (
  input  wire logic            clk,
  input  wire logic            rst,
  video_sprite_loader_if.slave bus
);

  localparam int                   RGB_W      = `RGB_SIZE;
  localparam int                   c_NPIX     = SPRITE_HSIZE * SPRITE_VSIZE;
  localparam logic [SPRITE_AW-1:0] c_LAST_PIX = SPRITE_AW'(c_NPIX - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2
  } state_t;

  state_t                   r_state;
  logic [SPRITE_IDXW-1:0]   r_idx;
  logic [SPRITE_AW-1:0]     r_pix_cnt;
  logic [7:0]               r_lo;
  logic                     r_we;
  logic [SPRITE_RAM_AW-1:0] r_addr;
  logic [RGB_W-1:0]         r_din;
  logic                     r_done;
  logic                     r_error;

  logic                     w_rdy;
  logic                     w_unused_hi;

  assign w_rdy       = (r_state != ST_IDLE);
  // High-byte bits above the colour width are intentionally dropped.
  assign w_unused_hi = ^bus.s_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_pix_cnt <= '0;
      r_lo      <= '0;
      r_we      <= 1'b0;
      r_addr    <= '0;
      r_din     <= '0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            if (int'(bus.start_idx) < SPRITE_NUM) begin
              r_idx     <= bus.start_idx;
              r_pix_cnt <= '0;
              r_state   <= ST_LO;
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        ST_LO: begin
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.s_vld) begin
            r_lo    <= bus.s_data;
            r_state <= ST_HI;
          end
        end
        ST_HI: begin
          // Abort beats a same-cycle high byte, so the half pixel is dropped.
          if (bus.abort) begin
            r_state <= ST_IDLE;
          end else if (bus.s_vld) begin
            r_we   <= 1'b1;
            r_addr <= SPRITE_RAM_AW'({r_idx, r_pix_cnt});
            r_din  <= {bus.s_data[RGB_W-9:0], r_lo};
            if (r_pix_cnt == c_LAST_PIX) begin
              r_done  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
              r_state   <= ST_LO;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.s_rdy             = w_rdy;
  assign bus.busy              = w_rdy;
  assign bus.done              = r_done;
  assign bus.error             = r_error;
  assign bus.sprite_ram_we     = r_we;
  assign bus.sprite_ram_addr_w = r_addr;
  assign bus.sprite_ram_din    = r_din;

endmodule

`default_nettype wire
